// File: rtl/fir_bitserial_mac.sv
// fir_bitserial_mac: bit-serial signed FIR multiply-accumulate, one sample bit per cycle across all taps.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module fir_bitserial_mac #(
  parameter int TAPS = 4,
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int AW   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DW-1:0]           sample_in,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [CW-1:0]           coef_data,
  output logic [AW-1:0]           sum_out,
  output logic                    sum_valid,
  output logic                    busy
);

  localparam int BW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  logic [DW-1:0]        taps  [TAPS];
  logic signed [CW-1:0] coefs [TAPS];
  logic [AW-1:0]        acc;
  logic [AW-1:0]        partial;
  logic [AW-1:0]        shifted;
  logic [BW-1:0]        bit_cnt;

  // Sum of sign-extended coefficients whose tap has the current bit set.
  always_comb begin
    partial = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (taps[k][bit_cnt]) begin
        partial = partial + AW'(coefs[k]);
      end
    end
  end

  assign shifted  = partial << bit_cnt;
  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      for (int k = 0; k < TAPS; k++) begin
        taps[k]  <= '0;
        coefs[k] <= '0;
      end
      acc       <= '0;
      bit_cnt   <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (coef_we && (int'(coef_addr) < TAPS)) begin
            coefs[coef_addr] <= coef_data;
          end
          if (in_valid) begin
            for (int k = TAPS - 1; k > 0; k--) begin
              taps[k] <= taps[k-1];
            end
            taps[0] <= sample_in;
            acc     <= '0;
            bit_cnt <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          state <= ACCUM;
        end
        ACCUM: begin
          // The sample MSB carries negative weight in two's complement.
          if (bit_cnt == BW'(DW - 1)) begin
            acc   <= acc - shifted;
            state <= DONE;
          end else begin
            acc     <= acc + shifted;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DONE: begin
          sum_out   <= acc;
          sum_valid <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_bitserial_mac.sv
// tb_fir_bitserial_mac: scoreboard bench with a product-sum reference model for fir_bitserial_mac.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_fir_bitserial_mac;

  localparam int TAPS = 4;
  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int AW   = 32;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          in_valid  = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic          coef_we   = 1'b0;
  logic [1:0]    coef_addr = '0;
  logic [CW-1:0] coef_data = '0;
  logic          in_ready;
  logic [AW-1:0] sum_out;
  logic          sum_valid;
  logic          busy;

  fir_bitserial_mac #(.TAPS(TAPS), .DW(DW), .CW(CW), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sample_in (sample_in),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .sum_out   (sum_out),
    .sum_valid (sum_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    int          c;
  } exp_t;

  int                 n_cmp = 0;
  int                 n_bad = 0;
  int                 cyc = 0;
  int                 last_accept = -1000;
  logic signed [15:0] mtap  [TAPS];
  logic signed [15:0] mcoef [TAPS];
  exp_t               sbq[$];
  exp_t               holdq[$];
  logic [31:0]        held = '0;
  logic [31:0]        got_q[$];

  function automatic bit model_busy(int c);
    return (c >= last_accept + 1) && (c <= last_accept + DW + 2);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: delay line and coefficient table updated from driven inputs.
  always @(posedge clk) begin
    int    p;
    bit    idle;
    longint s;
    exp_t  e;
    p = cyc + 1;
    if (reset) begin
      last_accept = -1000;
      sbq.delete();
      holdq.delete();
      held = '0;
      for (int k = 0; k < TAPS; k++) begin
        mtap[k]  = '0;
        mcoef[k] = '0;
      end
    end else begin
      idle = !model_busy(cyc);
      if (coef_we && idle) mcoef[coef_addr] = coef_data;
      if (in_valid && idle) begin
        for (int k = TAPS - 1; k > 0; k--) mtap[k] = mtap[k-1];
        mtap[0] = sample_in;
        s = 0;
        for (int k = 0; k < TAPS; k++) s += longint'(mtap[k]) * longint'(mcoef[k]);
        e.v = 32'(s);
        e.c = cyc + DW + 3;
        sbq.push_back(e);
        holdq.push_back(e);
        last_accept = cyc;
      end
      if (holdq.size() > 0 && holdq[0].c == p) begin
        held = holdq[0].v;
        void'(holdq.pop_front());
      end
    end
    cyc = p;
  end

  // Monitor: handshake state, result strobes and held output.
  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      check("in_ready", 32'(in_ready), 32'(!model_busy(cyc)));
      check("busy", 32'(busy), 32'(model_busy(cyc)));
      if (sum_valid) begin
        got_q.push_back(sum_out);
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_sum_valid: got sum_valid=1 expected 0 (sum_out 0x%08h, cycle %0d)", sum_out, cyc);
        end else begin
          e = sbq.pop_front();
          check("sum_out", sum_out, e.v);
          check("sum_time", 32'(cyc), 32'(e.c));
        end
      end else begin
        if (sbq.size() > 0 && sbq[0].c <= cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL missing_sum_valid: got sum_valid=0 expected 1 with 0x%08h (cycle %0d)", sbq[0].v, cyc);
          void'(sbq.pop_front());
        end
        check("sum_hold", sum_out, held);
      end
    end
  end

  task automatic send(logic [15:0] s, bit wr = 1'b0, int a = 0, logic [15:0] d = '0);
    int n = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    sample_in = s;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    if (wr) begin
      coef_we   = 1'b1;
      coef_addr = 2'(a);
      coef_data = d;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    coef_we   = 1'b0;
    sample_in = 16'($urandom);
  endtask

  task automatic wcoef(int a, logic [15:0] d);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = 2'(a);
    coef_data = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    got_q.delete();
  endtask

  task automatic check_got(string name, int idx, logic [31:0] exp);
    if (got_q.size() > idx) check(name, got_q[idx], exp);
    else check({name, "_count"}, 32'(got_q.size()), 32'(idx + 1));
  endtask

  initial begin
    logic [15:0] imp [5];
    logic [31:0] imp_exp [5];
    imp     = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
    imp_exp = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0};

    repeat (3) @(negedge clk);
    check("reset_sum_out", sum_out, 32'h0);
    check("reset_sum_valid", 32'(sum_valid), 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'h1);
    reset = 1'b0;

    // Single tap, positive sample
    wcoef(0, 16'd1);
    send(16'd100);
    drain();
    check_got("single_tap", 0, 32'd100);

    // Signed operands
    got_q.delete();
    wcoef(0, 16'hFFFD);
    send(16'hFFFB);
    send(16'h7FFF);
    drain();
    check_got("signed_neg_neg", 0, 32'd15);
    check_got("signed_pos_neg", 1, 32'hFFFE_8003);

    // Impulse response, back-to-back accepts
    do_reset();
    for (int k = 0; k < 4; k++) wcoef(k, 16'(k + 1));
    for (int i = 0; i < 5; i++) send(imp[i]);
    drain();
    for (int i = 0; i < 5; i++) check_got("impulse", i, imp_exp[i]);

    // Wrap-around modulo 2^32
    do_reset();
    for (int k = 0; k < 4; k++) wcoef(k, 16'h8000);
    for (int i = 0; i < 4; i++) send(16'h8000);
    drain();
    check_got("wrap_third", 2, 32'hC000_0000);
    check_got("wrap_fourth", 3, 32'h0);

    // Coefficient write ignored while busy, applied in idle
    do_reset();
    wcoef(0, 16'd5);
    send(16'd2);
    repeat (4) @(negedge clk);
    wcoef(0, 16'd7);
    drain();
    wcoef(0, 16'd7);
    send(16'd3);
    drain();
    check_got("busy_write_ignored", 0, 32'd10);
    check_got("idle_write_applied", 1, 32'd21);

    // Write and accept on the same edge
    got_q.delete();
    send(16'd4, 1'b1, 0, 16'hFFFE);
    drain();
    check_got("same_edge_write", 0, 32'hFFFF_FFF8);

    // Reset mid-accumulate
    for (int k = 1; k < 4; k++) wcoef(k, 16'(k));
    send(16'd6);
    repeat (6) @(negedge clk);
    do_reset();
    repeat (25) @(negedge clk);
    check("abort_sum_out", sum_out, 32'h0);
    check("abort_in_ready", 32'(in_ready), 32'h1);
    check("abort_no_result", 32'(got_q.size()), 32'h0);
    for (int k = 0; k < 4; k++) wcoef(k, 16'(k + 1));
    send(16'd9);
    drain();
    check_got("after_abort", 0, 32'd9);

    // Randomized traffic with stalls and mixed-timing coefficient writes
    for (int i = 0; i < 40; i++) begin
      logic [15:0] s;
      int          op;
      case ($urandom_range(0, 5))
        0:       s = 16'h8000;
        1:       s = 16'h7FFF;
        default: s = 16'($urandom);
      endcase
      op = $urandom_range(0, 3);
      if (op == 0) wcoef($urandom_range(0, 3), 16'($urandom));
      if (op == 2) send(s, 1'b1, $urandom_range(0, 3), 16'($urandom));
      else send(s);
      if (op == 1) begin
        repeat ($urandom_range(1, 10)) @(negedge clk);
        wcoef($urandom_range(0, 3), 16'($urandom));
      end
      if (op == 3) repeat ($urandom_range(0, 25)) @(negedge clk);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running expected finish before 1000000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/fir_bitserial_mac.md
# fir_bitserial_mac

Bit-serial multiply-accumulate engine for the FIR filter datapath. It accepts one signed 16-bit sample per handshake, shifts the sample into a tap delay line, and forms the filter sum over DW cycles, processing one sample bit per cycle across all taps. When the sum is complete it presents the 32-bit result with a one-cycle `sum_valid` strobe. `sum_valid` drives the `enable` of the downstream 32-bit output register, which captures `sum_out`.

## Interface
- `TAPS`, 4: number of filter taps and coefficients.
- `DW`, 16: sample width in bits, signed two's complement. Also the number of accumulate cycles.
- `CW`, 16: coefficient width in bits, signed two's complement.
- `AW`, 32: accumulator and `sum_out` width.
- `clk` input 1: single clock. All logic updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: `sample_in` is valid.
- `in_ready` output 1: block can accept a sample.
- `sample_in` input DW: signed input sample.
- `coef_we` input 1: coefficient write strobe.
- `coef_addr` input clog2(TAPS): index of the coefficient to write.
- `coef_data` input CW: signed coefficient value.
- `sum_out` output AW: filter result, held between strobes.
- `sum_valid` output 1: one-cycle strobe when `sum_out` is new.
- `busy` output 1: high in the LOAD, ACCUM and DONE states.

## Operation
- **Reset:** while `reset` is high at a rising edge:
  - the state goes to IDLE;
  - all tap registers, coefficients, the accumulator, the bit counter and `sum_out` clear to 0;
  - `sum_valid` clears to 0.
- **Reset priority:** reset overrides every other input in the same cycle.
- **States:** IDLE, LOAD, ACCUM, DONE.
- **IDLE:** `in_ready`=1.
  - On `in_valid` && `in_ready`: tap[k] <= tap[k-1] for k=TAPS-1..1, and tap[0] <= `sample_in`.
  - On the same edge: acc <= 0, bit counter b <= 0, next state LOAD.
- **LOAD:** one cycle for operand setup. The taps are frozen. Next state ACCUM.
- **ACCUM:** runs for DW cycles, b = 0..DW-1.
  - Partial sum: p = Σ over k of (tap[k][b] ? sign_ext(coef[k]) : 0), computed at AW width.
  - For b < DW-1: acc <= acc + (p << b).
  - For b = DW-1 (sample sign bit): acc <= acc − (p << (DW-1)).
  - After b = DW-1 the next state is DONE.
- **DONE:** one cycle.
  - `sum_out` <= acc and `sum_valid` <= 1 are registered; both become visible in the cycle after DONE.
  - Next state IDLE.
- **Arithmetic:** all arithmetic is modulo 2^AW, with no saturation and no overflow flag.
  - The result equals Σ tap[k]·coef[k] truncated to AW bits.
- **Coefficient writes:** a write to coef[`coef_addr`] takes effect only when the state is IDLE. When `busy`=1, `coef_we` is ignored.
- **Write and accept in the same IDLE cycle:** both happen on that edge, and the accumulation uses the newly written coefficient.
- **Delay line:** empty taps contribute 0 because of the reset clear. The oldest sample is discarded on each accept.
- **Stalls:** `in_valid` while `busy` has no effect. The upstream source holds the sample until `in_ready`.
- **`sum_out`** holds its value until the next DONE.

## Timing
- Accept edge is T0, when `in_valid` && `in_ready` are sampled high.
- LOAD occupies cycle T0+1.
- ACCUM occupies cycles T0+2 to T0+DW+1.
- DONE occupies cycle T0+DW+2.
- `sum_out` and `sum_valid` are visible at T0+DW+3 (T0+19 with defaults).
- `sum_valid` is high for exactly one cycle.
- `in_ready` returns to 1 in cycle T0+DW+3, the same cycle as `sum_valid`.
- Earliest next accept is therefore the edge ending T0+DW+3.
- Throughput is one sample per DW+3 cycles.
- `busy` = !`in_ready` at all times. `in_ready` is a function of the state only, with no combinational path from `in_valid`.
- **Reset mid-operation:** the operation aborts, no `sum_valid` is produced, and `in_ready`=1 in the cycle after reset deasserts.

## Test plan
- **Single tap, positive:** write coef = {1,0,0,0}, accept sample 100 → `sum_out`=100 with `sum_valid` pulsed once at T0+19; `in_ready` is low for T0+1..T0+18.
- **Signed operands:** write coef0 = −3, accept sample −5 → `sum_out`=15. Then accept sample 0x7FFF → `sum_out`=0xFFFE_8003 (−98301). Tap 1 now holds −5 but coef1 = 0, so it contributes nothing.
- **Impulse response:** write coef = {1,2,3,4}, accept samples 1,0,0,0,0 back-to-back → successive `sum_out` values 1,2,3,4,0.
- **Wrap-around:** write all coefs = 0x8000, accept 0x8000 four times → the fourth result is 4·2^30 mod 2^32 = 0; the third result is 0xC000_0000.
- **Coefficient writes ignored while busy:** assert `coef_we` to coef0 with 7 during ACCUM → no effect on the current result. Repeat the same write in IDLE → it applies to the next sample.
- **Reset mid-ACCUM:** assert `reset` at T0+8 → no `sum_valid`, `sum_out`=0, and all taps cleared. The next sample 9 with coef0 = 1 (rewritten) → 9.
